// File: rtl/m_stage_lsu_if.sv
// m_stage_lsu_if: X-stage issue, dmem response and W-stage result bundle for the M stage.
interface m_stage_lsu_if #(
  parameter int XLEN = 32,
  parameter int RF_CTRL_W = 6
);
  logic vld_in;
  logic [XLEN-1:0] exe_data_in;
  logic is_load;
  logic [1:0] ld_size;
  logic ld_unsigned;
  logic [RF_CTRL_W-1:0] rf_ctrl_in;
  logic dmem_rsp_vld;
  logic [XLEN-1:0] dmem_rsp_data;
  logic stall_in;
  logic squash_in;
  logic vld;
  logic [XLEN-1:0] data_out;
  logic [RF_CTRL_W-1:0] rf_ctrl_out;
  logic stall;
  logic squash;
  logic misalign_err;
  logic bus_err;
  modport slave (
    input vld_in, exe_data_in, is_load, ld_size, ld_unsigned, rf_ctrl_in,
    input dmem_rsp_vld, dmem_rsp_data, stall_in, squash_in,
    output vld, data_out, rf_ctrl_out, stall, squash, misalign_err, bus_err
  );
  modport master (
    output vld_in, exe_data_in, is_load, ld_size, ld_unsigned, rf_ctrl_in,
    output dmem_rsp_vld, dmem_rsp_data, stall_in, squash_in,
    input vld, data_out, rf_ctrl_out, stall, squash, misalign_err, bus_err
  );
endinterface

// File: rtl/m_stage_lsu.sv
// m_stage_lsu: M-stage pipeline registers with variable-latency load response handling,
// response buffering under downstream stall, sub-word load formatting, squash drain and timeout.
module m_stage_lsu #(
  parameter int XLEN = 32,
  parameter int RF_CTRL_W = 6,
  parameter int TIMEOUT = 0
) (
  input logic clk,
  input logic rst,
  m_stage_lsu_if.slave bus
);
  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int LW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, WAIT, HAVE, DRAIN} st_t;
  st_t st_q, st_d;
  logic valid_q, load_q, uns_q;
  logic [1:0] size_q;
  logic [XLEN-1:0] exe_q, buf_q, buf_d;
  logic [RF_CTRL_W-1:0] rf_q;
  logic [31:0] cnt_q, cnt_d;
  logic gen_stall, to, stall_w, ld_v, waiting;
  logic [OFF_W-1:0] off;
  logic [1:0] sz_e;
  logic [6:0] nb, msb;
  logic [XLEN-1:0] src, sh, mask, ext;
  logic sgn;
  assign ld_v = valid_q & load_q;
  assign waiting = st_q == WAIT || st_q == DRAIN;
  assign to = TIMEOUT > 0 && waiting && !bus.dmem_rsp_vld && cnt_q == 32'(TIMEOUT - 1);
  assign stall_w = bus.stall_in | gen_stall;
  always_comb begin
    st_d = st_q;
    buf_d = buf_q;
    gen_stall = 1'b0;
    case (st_q)
      IDLE:
        if (ld_v && !bus.squash_in) begin
          if (!bus.dmem_rsp_vld) begin
            gen_stall = 1'b1;
            st_d = WAIT;
          end else if (bus.stall_in) begin
            st_d = HAVE;
            buf_d = bus.dmem_rsp_data;
          end
        end
      WAIT: begin
        gen_stall = !to;
        if (bus.squash_in) begin
          st_d = (bus.dmem_rsp_vld || to) ? IDLE : DRAIN;
        end else if (bus.dmem_rsp_vld) begin
          st_d = HAVE;
          buf_d = bus.dmem_rsp_data;
        end else if (to) begin
          st_d = bus.stall_in ? HAVE : IDLE;
          buf_d = '0;
        end
      end
      HAVE: st_d = (bus.squash_in || !bus.stall_in) ? IDLE : HAVE;
      DRAIN: begin
        gen_stall = 1'b1;
        st_d = (bus.dmem_rsp_vld || to) ? IDLE : DRAIN;
      end
    endcase
    cnt_d = (waiting && (st_d == WAIT || st_d == DRAIN)) ? cnt_q + 32'd1 : '0;
  end
  // Word-sized load on a 32-bit datapath stands in for an illegal double.
  assign off = exe_q[OFF_W-1:0];
  assign sz_e = (XLEN == 32 && size_q == 2'd3) ? 2'd2 : size_q;
  assign nb = 7'd8 << sz_e;
  assign msb = nb - 7'd1;
  assign src = st_q == HAVE ? buf_q : bus.dmem_rsp_data;
  assign sh = src >> {off, 3'b000};
  assign mask = ~({XLEN{1'b1}} << nb);
  assign sgn = !uns_q && sh[msb[LW-1:0]];
  assign ext = (sh & mask) | ({XLEN{sgn}} & ~mask);
  assign bus.data_out = (st_q == WAIT && to) ? '0 : load_q ? ext : exe_q;
  assign bus.vld = valid_q & !gen_stall & !bus.squash_in;
  assign bus.stall = stall_w;
  assign bus.squash = bus.squash_in;
  assign bus.rf_ctrl_out = rf_q;
  assign bus.bus_err = to;
  assign bus.misalign_err = ld_v & ((sz_e == 2'd1 & off[0]) | (sz_e == 2'd2 & off[1:0] != 2'd0) |
                                    (sz_e == 2'd3 & off != '0));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      buf_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      exe_q <= '0;
      load_q <= 1'b0;
      size_q <= '0;
      uns_q <= 1'b0;
      rf_q <= '0;
    end else begin
      st_q <= st_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      if (!stall_w) begin
        valid_q <= bus.vld_in;
        exe_q <= bus.exe_data_in;
        load_q <= bus.is_load;
        size_q <= bus.ld_size;
        uns_q <= bus.ld_unsigned;
        rf_q <= bus.rf_ctrl_in;
      end else if (bus.squash_in) begin
        valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_m_stage_lsu.sv
// tb_m_stage_lsu: directed and randomized checks of the M-stage LSU against an arithmetic load model.
module tb_m_stage_lsu;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  bit cur_mis = 1'b0;
  logic [5:0] cur_rf = '0;
  m_stage_lsu_if #(.XLEN(32), .RF_CTRL_W(6)) bus ();
  m_stage_lsu #(.XLEN(32), .RF_CTRL_W(6), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  function automatic logic [31:0] fmt(input logic [31:0] a, input logic [1:0] s, input bit u,
                                      input logic [31:0] r);
    int bits;
    longint unsigned v;
    bits = (s == 2'd0) ? 8 : (s == 2'd1) ? 16 : 32;
    v = {32'd0, r};
    v = v >> (8 * (a % 4));
    v = v % (64'd1 << bits);
    if (!u && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction
  function automatic bit misal(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd1 && a % 2 != 0) || (s >= 2'd2 && a % 4 != 0);
  endfunction
  task automatic cyc(input string tag, input bit ev, input logic [31:0] ed, input bit es);
    chk({tag, ".vld"}, bus.vld, ev);
    chk({tag, ".stall"}, bus.stall, es);
    chk({tag, ".bus_err"}, bus.bus_err, 0);
    chk({tag, ".misalign"}, bus.misalign_err, cur_mis);
    if (ev) begin
      chk({tag, ".data"}, bus.data_out, ed);
      chk({tag, ".rf"}, bus.rf_ctrl_out, cur_rf);
    end
  endtask
  task automatic scramble();
    bus.exe_data_in = $urandom;
    bus.is_load = 1'($urandom);
    bus.ld_size = 2'($urandom);
    bus.ld_unsigned = 1'($urandom);
    bus.rf_ctrl_in = 6'($urandom);
  endtask
  task automatic issue(input bit ld, input logic [31:0] addr, input logic [1:0] sz, input bit uns);
    bus.vld_in = 1'b1;
    bus.exe_data_in = addr;
    bus.is_load = ld;
    bus.ld_size = sz;
    bus.ld_unsigned = uns;
    cur_rf = 6'($urandom);
    bus.rf_ctrl_in = cur_rf;
    bus.stall_in = 1'b0;
    bus.squash_in = 1'b0;
    bus.dmem_rsp_vld = 1'b0;
    @(negedge clk);
    bus.vld_in = 1'b0;
    scramble();
    cur_mis = ld && misal(addr, sz);
  endtask
  // One instruction end to end: lat idle cycles before the response, hold cycles of downstream stall.
  task automatic do_op(input string tag, input bit ld, input logic [31:0] addr, input logic [1:0] sz,
                       input bit uns, input logic [31:0] rsp, input int lat, input int hold);
    logic [31:0] exp;
    int n;
    exp = ld ? fmt(addr, sz, uns, rsp) : addr;
    issue(ld, addr, sz, uns);
    if (ld) for (int k = 0; k < lat; k++) begin
      #1 cyc({tag, ".wait"}, 1'b0, 32'd0, 1'b1);
      @(negedge clk);
    end
    bus.dmem_rsp_vld = ld ? 1'b1 : 1'($urandom);
    bus.dmem_rsp_data = rsp;
    bus.stall_in = hold > 0;
    #1;
    if (!ld || lat == 0) cyc({tag, ".rsp"}, 1'b1, exp, hold > 0);
    else cyc({tag, ".rsp"}, 1'b0, exp, 1'b1);
    @(negedge clk);
    bus.dmem_rsp_vld = 1'b0;
    bus.dmem_rsp_data = $urandom;
    n = (ld && lat > 0) ? hold + 1 : hold;
    for (int i = 0; i < n; i++) begin
      bus.stall_in = i < n - 1;
      #1 cyc({tag, ".have"}, 1'b1, exp, i < n - 1);
      @(negedge clk);
    end
    bus.stall_in = 1'b0;
    cur_mis = 1'b0;
  endtask
  initial begin
    int stalls;
    rst = 1'b1;
    bus.vld_in = 1'b0;
    bus.exe_data_in = '0;
    bus.is_load = 1'b0;
    bus.ld_size = '0;
    bus.ld_unsigned = 1'b0;
    bus.rf_ctrl_in = '0;
    bus.dmem_rsp_vld = 1'b0;
    bus.dmem_rsp_data = '0;
    bus.stall_in = 1'b0;
    bus.squash_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.vld", bus.vld, 0);
    chk("reset.data", bus.data_out, 0);
    chk("reset.rf", bus.rf_ctrl_out, 0);
    chk("reset.stall", bus.stall, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("idle.stall", bus.stall, 0);
    @(negedge clk);
    do_op("lb_same", 1'b1, 32'h1003, 2'd0, 1'b0, 32'h80FF_0000, 0, 0);
    issue(1'b1, 32'h2, 2'd1, 1'b1);
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      bus.dmem_rsp_vld = k == 2;
      bus.dmem_rsp_data = 32'hBEEF_1234;
      #1 stalls += int'(bus.stall);
      chk("lhu.vld_wait", bus.vld, 0);
      @(negedge clk);
    end
    bus.dmem_rsp_vld = 1'b0;
    #1;
    chk("lhu.stall_cycles", stalls, 3);
    chk("lhu.stall_after", bus.stall, 0);
    chk("lhu.vld", bus.vld, 1);
    chk("lhu.data", bus.data_out, 32'h0000_BEEF);
    @(negedge clk);
    cur_mis = 1'b0;
    do_op("lw_held", 1'b1, 32'h40, 2'd2, 1'b0, 32'hDEAD_BEEF, 1, 2);
    #1 chk("lw_held.after_vld", bus.vld, 0);
    @(negedge clk);
    issue(1'b1, 32'h80, 2'd2, 1'b0);
    #1 chk("sq.idle_stall", bus.stall, 1);
    @(negedge clk);
    bus.squash_in = 1'b1;
    #1 cyc("sq.wait", 1'b0, 32'd0, 1'b1);
    chk("sq.squash_out", bus.squash, 1);
    @(negedge clk);
    bus.squash_in = 1'b0;
    cur_mis = 1'b0;
    #1 cyc("sq.drain", 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    bus.dmem_rsp_vld = 1'b1;
    bus.dmem_rsp_data = 32'h5555_AAAA;
    #1 cyc("sq.drain_rsp", 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    bus.dmem_rsp_vld = 1'b0;
    #1 cyc("sq.idle", 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    do_op("sq.next", 1'b1, 32'h84, 2'd2, 1'b0, 32'h0102_0304, 1, 0);
    issue(1'b1, 32'h100, 2'd2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1 cyc("to.wait", 1'b0, 32'd0, 1'b1);
      @(negedge clk);
    end
    #1;
    chk("to.bus_err", bus.bus_err, 1);
    chk("to.vld", bus.vld, 1);
    chk("to.data", bus.data_out, 0);
    chk("to.stall", bus.stall, 0);
    @(negedge clk);
    cur_mis = 1'b0;
    #1 cyc("to.after", 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    issue(1'b1, 32'h6, 2'd2, 1'b0);
    #1 chk("rst.wait_stall", bus.stall, 1);
    chk("mis.word6", bus.misalign_err, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst.async_stall", bus.stall, 0);
    chk("rst.async_vld", bus.vld, 0);
    @(negedge clk);
    rst = 1'b0;
    cur_mis = 1'b0;
    bus.dmem_rsp_vld = 1'b1;
    #1 cyc("rst.stray", 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    bus.dmem_rsp_vld = 1'b0;
    do_op("mis.w6", 1'b1, 32'h6, 2'd2, 1'b0, 32'h1122_3344, 0, 0);
    do_op("alu", 1'b0, 32'h1234, 2'd0, 1'b0, 32'hFFFF_FFFF, 0, 0);
    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rnd%0d", i), ($urandom % 4) != 0, $urandom, 2'($urandom), 1'($urandom),
            $urandom, int'($urandom % 4), int'($urandom % 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
